// File: rtl/memory_controller.sv
// -----------------------------------------------------------------------------
// memory_controller
//
// Sole owner of the byte-wide RAM/IO port. Arbitrates three level-held
// requesters (store > load > instruction fetch), serialises each access into
// 1, 2 or 4 byte cycles, assembles little-endian read data, sign/zero-extends
// load results and returns a one-cycle finish pulse to the winning requester.
//
// Ports
//   clk_in, rst_in        clock, synchronous active-high reset
//   rdy_in                low = pause, every register holds and mem_wr is 0
//   roll_back             mispredict flush; aborts an in-flight read
//   io_buffer_full        stores into [IO_BASE, IO_TOP] wait while high
//   mem_din/mem_dout      RAM read / write byte
//   mem_a, mem_wr         RAM address and write strobe
//   if_req/if_addr        fetch request; if_finish/if_data response
//   lsb_store/...         store request (SB/SH/SW); finish_store response
//   lsb_load/...          load request (LB/LH/LW/LBU/LHU); finish_load/data_load
// -----------------------------------------------------------------------------
module memory_controller #(
    parameter logic [31:0] IO_BASE = 32'h0003_0000,
    parameter logic [31:0] IO_TOP  = 32'h0003_0007
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        roll_back,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_finish,
    output logic [31:0] if_data,
    input  logic        lsb_store,
    input  logic [31:0] store_address,
    input  logic [31:0] data_store,
    input  logic [2:0]  op_type_store,
    output logic        finish_store,
    input  logic        lsb_load,
    input  logic [31:0] load_address,
    input  logic [2:0]  op_type_load,
    output logic        finish_load,
    output logic [31:0] data_load
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_e;
    typedef enum logic [1:0] {K_FETCH, K_LOAD, K_STORE} kind_e;

    // Index of the last byte of an access, from funct3[1:0].
    function automatic logic [1:0] last_index(input logic [1:0] size);
        case (size)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] op, input logic [31:0] w);
        case (op)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'd0, w[7:0]};
            3'b101:  return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    state_e      state_q, state_d;
    kind_e       kind_q, kind_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  last_q, last_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic        mem_wr_q, mem_wr_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        if_finish_q, if_finish_d;
    logic        finish_load_q, finish_load_d;
    logic        finish_store_q, finish_store_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] data_load_q, data_load_d;

    logic        store_is_io;
    logic        store_ok;
    logic        accept;
    kind_e       sel_kind;
    logic [31:0] sel_addr;
    logic [2:0]  sel_op;
    logic [1:0]  idx_nxt;
    logic [31:0] rword;

    assign store_is_io = (store_address >= IO_BASE) && (store_address <= IO_TOP);

    // Arbitration: a store blocked on a full IO buffer lets a load or fetch
    // through instead of stalling the whole port.
    // NOTE: every signal written in an always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        store_ok = lsb_store && !(store_is_io && io_buffer_full);
        accept   = !roll_back && (store_ok || lsb_load || if_req);
        sel_kind = K_FETCH;
        sel_addr = if_addr;
        sel_op   = 3'b010;
        if (store_ok) begin
            sel_kind = K_STORE;
            sel_addr = store_address;
            sel_op   = op_type_store;
        end else if (lsb_load) begin
            sel_kind = K_LOAD;
            sel_addr = load_address;
            sel_op   = op_type_load;
        end
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk_in) begin
        if (rst_in) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic. rdy_in low freezes everything.
    always_comb begin
        state_d = state_q;
        if (rdy_in) begin
            case (state_q)
                S_IDLE:  if (accept) state_d = (sel_kind == K_STORE) ? S_WRITE : S_READ;
                S_READ: begin
                    if (roll_back)            state_d = S_IDLE;
                    else if (idx_q == last_q) state_d = S_DONE;
                end
                // A committed store always runs to completion.
                S_WRITE: if (idx_q == last_q) state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath / output next-state logic.
    always_comb begin
        idx_nxt = idx_q + 2'd1;
        // Read word with the byte arriving this cycle merged in place.
        rword = rbuf_q;
        rword[{idx_q, 3'b000} +: 8] = mem_din;

        kind_d         = kind_q;
        addr_d         = addr_q;
        op_d           = op_q;
        last_d         = last_q;
        idx_d          = idx_q;
        wdata_d        = wdata_q;
        rbuf_d         = rbuf_q;
        mem_a_d        = mem_a_q;
        mem_wr_d       = mem_wr_q;
        mem_dout_d     = mem_dout_q;
        if_finish_d    = if_finish_q;
        finish_load_d  = finish_load_q;
        finish_store_d = finish_store_q;
        if_data_d      = if_data_q;
        data_load_d    = data_load_q;

        if (rdy_in) begin
            if_finish_d    = 1'b0;
            finish_load_d  = 1'b0;
            finish_store_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        kind_d  = sel_kind;
                        addr_d  = sel_addr;
                        op_d    = sel_op;
                        last_d  = last_index(sel_op[1:0]);
                        idx_d   = 2'd0;
                        wdata_d = data_store;
                        rbuf_d  = 32'd0;
                        mem_a_d = sel_addr;
                        if (sel_kind == K_STORE) begin
                            mem_wr_d   = 1'b1;
                            mem_dout_d = data_store[7:0];
                        end
                    end
                end
                S_READ: begin
                    // On roll_back nothing is captured and mem_a is left as is.
                    if (!roll_back) begin
                        rbuf_d = rword;
                        if (idx_q == last_q) begin
                            if (kind_q == K_FETCH) begin
                                if_finish_d = 1'b1;
                                if_data_d   = rword;
                            end else begin
                                finish_load_d = 1'b1;
                                data_load_d   = extend(op_q, rword);
                            end
                        end else begin
                            idx_d   = idx_nxt;
                            mem_a_d = addr_q + {30'd0, idx_nxt};
                        end
                    end
                end
                S_WRITE: begin
                    if (idx_q == last_q) begin
                        mem_wr_d       = 1'b0;
                        finish_store_d = 1'b1;
                    end else begin
                        idx_d      = idx_nxt;
                        mem_a_d    = addr_q + {30'd0, idx_nxt};
                        mem_dout_d = wdata_q[{idx_nxt, 3'b000} +: 8];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            kind_q         <= K_FETCH;
            addr_q         <= 32'd0;
            op_q           <= 3'd0;
            last_q         <= 2'd0;
            idx_q          <= 2'd0;
            wdata_q        <= 32'd0;
            rbuf_q         <= 32'd0;
            mem_a_q        <= 32'd0;
            mem_wr_q       <= 1'b0;
            mem_dout_q     <= 8'd0;
            if_finish_q    <= 1'b0;
            finish_load_q  <= 1'b0;
            finish_store_q <= 1'b0;
            if_data_q      <= 32'd0;
            data_load_q    <= 32'd0;
        end else begin
            kind_q         <= kind_d;
            addr_q         <= addr_d;
            op_q           <= op_d;
            last_q         <= last_d;
            idx_q          <= idx_d;
            wdata_q        <= wdata_d;
            rbuf_q         <= rbuf_d;
            mem_a_q        <= mem_a_d;
            mem_wr_q       <= mem_wr_d;
            mem_dout_q     <= mem_dout_d;
            if_finish_q    <= if_finish_d;
            finish_load_q  <= finish_load_d;
            finish_store_q <= finish_store_d;
            if_data_q      <= if_data_d;
            data_load_q    <= data_load_d;
        end
    end

    // A paused cycle must not write; the held byte is reissued on resume.
    assign mem_wr       = mem_wr_q & rdy_in;
    assign mem_a        = mem_a_q;
    assign mem_dout     = mem_dout_q;
    assign if_finish    = if_finish_q;
    assign if_data      = if_data_q;
    assign finish_load  = finish_load_q;
    assign data_load    = data_load_q;
    assign finish_store = finish_store_q;

endmodule

// File: tb/tb_memory_controller.sv
// -----------------------------------------------------------------------------
// tb_memory_controller
//
// Directed bench for memory_controller. A byte RAM model answers mem_a
// combinationally and records every write. Expected responses are queued when
// a request is issued; a monitor pops and compares on each finish pulse.
// -----------------------------------------------------------------------------
module tb_memory_controller;

    typedef enum logic [1:0] {K_FETCH, K_LOAD, K_STORE} kind_e;
    typedef struct {
        kind_e       kind;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_in, rdy_in, roll_back, io_buffer_full;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_finish;
    logic [31:0] if_data;
    logic        lsb_store = 1'b0;
    logic [31:0] store_address = 32'd0, data_store = 32'd0;
    logic [2:0]  op_type_store = 3'd0;
    logic        finish_store;
    logic        lsb_load = 1'b0;
    logic [31:0] load_address = 32'd0;
    logic [2:0]  op_type_load = 3'd0;
    logic        finish_load;
    logic [31:0] data_load;

    memory_controller dut (
        .clk_in        (clk),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .roll_back     (roll_back),
        .io_buffer_full(io_buffer_full),
        .mem_din       (mem_din),
        .mem_dout      (mem_dout),
        .mem_a         (mem_a),
        .mem_wr        (mem_wr),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_finish     (if_finish),
        .if_data       (if_data),
        .lsb_store     (lsb_store),
        .store_address (store_address),
        .data_store    (data_store),
        .op_type_store (op_type_store),
        .finish_store  (finish_store),
        .lsb_load      (lsb_load),
        .load_address  (load_address),
        .op_type_load  (op_type_load),
        .finish_load   (finish_load),
        .data_load     (data_load)
    );

    always #5 clk = ~clk;

    // RAM model: 4 KiB, address taken modulo 4096 so wrap-around is visible.
    logic [7:0]  ram [0:4095];
    int          wcnt [0:4095];
    int          wtotal = 0;
    logic        pre_en = 1'b0;
    logic [11:0] pre_addr = 12'd0;
    logic [7:0]  pre_data = 8'd0;

    assign mem_din = ram[mem_a[11:0]];

    always @(posedge clk) begin
        if (pre_en) begin
            ram[pre_addr] <= pre_data;
        end else if (mem_wr) begin
            ram[mem_a[11:0]]  <= mem_dout;
            wcnt[mem_a[11:0]] <= wcnt[mem_a[11:0]] + 1;
            wtotal            <= wtotal + 1;
        end
    end

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    logic [31:0] a_trace[$];
    int   wr_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: one finish at a time, never two cycles in a row, in queue order.
    logic  prev_fin = 1'b0;
    int    nfin;
    exp_t  got;
    exp_t  want;
    always @(negedge clk) begin
        if (!rst_in) begin
            nfin = int'(if_finish) + int'(finish_load) + int'(finish_store);
            if (nfin != 0) begin
                check("finish_onehot", nfin, 1);
                check("finish_gap", {31'd0, prev_fin}, 32'd0);
                got.kind = finish_store ? K_STORE : (finish_load ? K_LOAD : K_FETCH);
                got.data = finish_load ? data_load : if_data;
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_finish");
                end else begin
                    want = exp_q.pop_front();
                    check("finish_kind", {30'd0, got.kind}, {30'd0, want.kind});
                    if (want.kind != K_STORE) check("read_data", got.data, want.data);
                end
            end
            prev_fin = (nfin != 0);
        end
    end

    task automatic push_exp(input kind_e k, input logic [31:0] d);
        exp_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic req_load(input logic [31:0] a, input logic [2:0] op, input logic [31:0] exp);
        push_exp(K_LOAD, exp);
        load_address = a;
        op_type_load = op;
        lsb_load     = 1'b1;
    endtask

    task automatic req_store(input logic [31:0] a, input logic [2:0] op, input logic [31:0] d);
        push_exp(K_STORE, 32'd0);
        store_address = a;
        op_type_store = op;
        data_store    = d;
        lsb_store     = 1'b1;
    endtask

    task automatic req_fetch(input logic [31:0] a, input logic [31:0] exp);
        push_exp(K_FETCH, exp);
        if_addr = a;
        if_req  = 1'b1;
    endtask

    // Acts as all three requesters: holds each level until its finish, then
    // drops it. lat = negedges until the first finish. One idle negedge at the
    // end so the controller is back in IDLE before the next request.
    task automatic wait_done(input int max_cyc, output int lat);
        int n;
        n = 0;
        lat = -1;
        a_trace.delete();
        wr_cyc = 0;
        while (lsb_store || lsb_load || if_req) begin
            @(negedge clk);
            n++;
            a_trace.push_back(mem_a);
            if (mem_wr) wr_cyc++;
            if (lat < 0 && (finish_store || finish_load || if_finish)) lat = n;
            if (finish_store) lsb_store = 1'b0;
            if (finish_load)  lsb_load  = 1'b0;
            if (if_finish)    if_req    = 1'b0;
            if (n >= max_cyc) begin
                fail_now("request_timeout");
                lsb_store = 1'b0;
                lsb_load  = 1'b0;
                if_req    = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int w0;
        bit store_seen;
        bit fetch_seen;

        rst_in = 1'b1;
        rdy_in = 1'b1;
        roll_back = 1'b0;
        io_buffer_full = 1'b0;
        @(negedge clk);

        // Preload while reset is held.
        poke(12'h100, 8'h11); poke(12'h101, 8'h22); poke(12'h102, 8'h33); poke(12'h103, 8'h44);
        poke(12'h020, 8'h80);
        poke(12'h040, 8'h01); poke(12'h041, 8'h80);
        poke(12'hFFE, 8'hAA); poke(12'hFFF, 8'hBB); poke(12'h000, 8'hCC); poke(12'h001, 8'hDD);
        poke(12'h202, 8'h5A);
        poke(12'h300, 8'h13); poke(12'h301, 8'h05); poke(12'h302, 8'h00); poke(12'h303, 8'h00);

        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        check("rst_finish", {29'd0, if_finish, finish_load, finish_store}, 32'd0);
        check("rst_if_data", if_data, 32'd0);
        check("rst_data_load", data_load, 32'd0);
        rst_in = 1'b0;
        @(negedge clk);

        // LW: latency and address sequence.
        req_load(32'h100, 3'b010, 32'h4433_2211);
        wait_done(20, lat);
        check("lw_latency", lat, 5);
        check("lw_a0", a_trace[0], 32'h100);
        check("lw_a1", a_trace[1], 32'h101);
        check("lw_a2", a_trace[2], 32'h102);
        check("lw_a3", a_trace[3], 32'h103);

        // Extension variants.
        req_load(32'h20, 3'b000, 32'hFFFF_FF80);
        wait_done(20, lat);
        check("lb_latency", lat, 2);
        req_load(32'h20, 3'b100, 32'h0000_0080);
        wait_done(20, lat);
        req_load(32'h40, 3'b001, 32'hFFFF_8001);
        wait_done(20, lat);
        check("lh_latency", lat, 3);
        req_load(32'h40, 3'b101, 32'h0000_8001);
        wait_done(20, lat);

        // Address wraps past 0xFFFFFFFF.
        req_load(32'hFFFF_FFFE, 3'b010, 32'hDDCC_BBAA);
        wait_done(20, lat);
        check("wrap_a2", a_trace[2], 32'h0);

        // SH: two byte writes, nothing else.
        w0 = wtotal;
        req_store(32'h200, 3'b001, 32'hABCD_1234);
        wait_done(20, lat);
        check("sh_latency", lat, 3);
        check("sh_wr_cycles", wr_cyc, 2);
        check("sh_a0", a_trace[0], 32'h200);
        check("sh_a1", a_trace[1], 32'h201);
        check("sh_writes", wtotal - w0, 2);
        check("sh_b0", {24'd0, ram[12'h200]}, 32'h34);
        check("sh_b1", {24'd0, ram[12'h201]}, 32'h12);
        check("sh_b2_kept", {24'd0, ram[12'h202]}, 32'h5A);

        // Plain fetch.
        req_fetch(32'h300, 32'h0000_0513);
        wait_done(20, lat);
        check("fetch_latency", lat, 5);

        // All three at once: store, then load, then fetch.
        req_store(32'h500, 3'b000, 32'h0000_0099);
        req_load(32'h20, 3'b100, 32'h0000_0080);
        req_fetch(32'h300, 32'h0000_0513);
        wait_done(40, lat);
        check("tri_store_first", lat, 2);
        check("tri_store_data", {24'd0, ram[12'h500]}, 32'h99);

        // IO store held off by io_buffer_full while a fetch goes through.
        io_buffer_full = 1'b1;
        w0 = wtotal;
        store_seen = 1'b0;
        fetch_seen = 1'b0;
        req_fetch(32'h100, 32'h4433_2211);
        store_address = 32'h0003_0000;
        op_type_store = 3'b000;
        data_store    = 32'h0000_0077;
        lsb_store     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (finish_store) store_seen = 1'b1;
            if (if_finish) begin
                fetch_seen = 1'b1;
                if_req = 1'b0;
            end
        end
        check("io_fetch_done", {31'd0, fetch_seen}, 32'd1);
        check("io_store_held", {31'd0, store_seen}, 32'd0);
        check("io_no_write", wtotal - w0, 0);
        push_exp(K_STORE, 32'd0);
        io_buffer_full = 1'b0;
        wait_done(20, lat);
        check("io_store_data", {24'd0, ram[12'h000]}, 32'h77);
        check("io_store_writes", wtotal - w0, 1);

        // roll_back while the second byte of an LW is in flight.
        load_address = 32'h100;
        op_type_load = 3'b010;
        lsb_load = 1'b1;
        @(negedge clk);
        @(negedge clk);
        roll_back = 1'b1;
        lsb_load  = 1'b0;
        @(negedge clk);
        roll_back = 1'b0;
        check("rb_no_finish", {31'd0, finish_load}, 32'd0);
        check("rb_mem_a_held", mem_a, 32'h101);
        req_load(32'h20, 3'b000, 32'hFFFF_FF80);
        wait_done(20, lat);
        check("rb_idle_next", lat, 2);

        // SW paused for three cycles after the first byte.
        w0 = wtotal;
        req_store(32'h400, 3'b010, 32'hDEAD_BEEF);
        @(negedge clk);
        @(negedge clk);
        rdy_in = 1'b0;
        @(negedge clk);
        check("pause_mem_wr", {31'd0, mem_wr}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rdy_in = 1'b1;
        wait_done(30, lat);
        check("sw_b0", {24'd0, ram[12'h400]}, 32'hEF);
        check("sw_b1", {24'd0, ram[12'h401]}, 32'hBE);
        check("sw_b2", {24'd0, ram[12'h402]}, 32'hAD);
        check("sw_b3", {24'd0, ram[12'h403]}, 32'hDE);
        for (int i = 0; i < 4; i++) check("sw_once", wcnt[12'h400 + i], 1);
        check("sw_writes", wtotal - w0, 4);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
